// File: rtl/gb_fb_pkg.sv
// Shared definitions for the Game Boy LCD capture path and the 160x144x2bpp
// framebuffer it feeds.
//   GB_H_PIX / GB_V_LINES : visible GB frame geometry
//   FB_DEPTH / FB_AW      : framebuffer word count and address width
//   gb_pix_t              : one 2bpp pixel
//   cap_state_t           : capture FSM state encoding
package gb_fb_pkg;

  localparam int GB_H_PIX   = 160;
  localparam int GB_V_LINES = 144;
  localparam int FB_DEPTH   = GB_H_PIX * GB_V_LINES;
  localparam int FB_AW      = 15;

  typedef logic [1:0] gb_pix_t;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } cap_state_t;

endpackage

// File: rtl/gb_sync_edge.sv
// Synchronizer plus registered single-edge detector for one asynchronous
// GB LCD control line.
//   clk     in  system clock
//   reset_n in  asynchronous active-low reset
//   din     in  asynchronous input
//   edge_p  out 1-cycle pulse on a rising (RISE=1) or falling (RISE=0) edge
// Pin-to-pulse latency is STAGES+1 clk cycles.
module gb_sync_edge #(
  parameter int STAGES = 2,
  parameter bit RISE   = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic edge_p
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              sync_out;

  assign sync_out = sync_q[STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      edge_p <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_out;
      edge_p <= RISE ? (sync_out & ~prev_q) : (~sync_out & prev_q);
    end
  end

endmodule

// File: rtl/gb_lcd_capture.sv
// Write side of the GB framebuffer: samples the asynchronous GB LCD bus and
// writes one 2-bit word per pixel at address y*H_PIX+x.
//   clk, reset_n        system clock, async active-low reset
//   gb_clk/hsync/vsync  GB LCD pixel clock, line latch, frame sync (async)
//   gb_d                GB pixel data (async), valid at gb_clk falling edge
//   capture_en          arms capture, sampled at a vsync rising edge
//   fb_wr_addr/data/we  framebuffer write port (we is a 1-cycle strobe)
//   frame_done          pulse when the last line of a frame completes
//   frame_err           pulse on vsync arriving mid-frame
//   line_err            pulse on the first dropped pixel of an overlong line
//   frame_count         completed frames (wraps)
//   err_count           error events (saturates at 255)
// Build option: define GB_CAPTURE_STATS_EN to build frame_count/err_count;
// otherwise both read 0 and no counter flops exist.
module gb_lcd_capture #(
  parameter int H_PIX       = gb_fb_pkg::GB_H_PIX,
  parameter int V_LINES     = gb_fb_pkg::GB_V_LINES,
  parameter int SYNC_STAGES = 2,
  parameter int FB_AW       = gb_fb_pkg::FB_AW
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             gb_clk,
  input  logic             gb_hsync,
  input  logic             gb_vsync,
  input  logic [1:0]       gb_d,
  input  logic             capture_en,
  output logic [FB_AW-1:0] fb_wr_addr,
  output logic [1:0]       fb_wr_data,
  output logic             fb_we,
  output logic             frame_done,
  output logic             frame_err,
  output logic             line_err,
  output logic [15:0]      frame_count,
  output logic [7:0]       err_count
);

  import gb_fb_pkg::*;

  // x saturates at H_PIX so it needs room for that value itself.
  localparam int XW = $clog2(H_PIX + 1);
  localparam int YW = (V_LINES > 1) ? $clog2(V_LINES) : 1;

  logic px_fall, hs_rise, vs_rise;

  gb_sync_edge #(.STAGES(SYNC_STAGES), .RISE(1'b0)) u_sync_clk (
    .clk(clk), .reset_n(reset_n), .din(gb_clk), .edge_p(px_fall)
  );

  gb_sync_edge #(.STAGES(SYNC_STAGES), .RISE(1'b1)) u_sync_hs (
    .clk(clk), .reset_n(reset_n), .din(gb_hsync), .edge_p(hs_rise)
  );

  gb_sync_edge #(.STAGES(SYNC_STAGES), .RISE(1'b1)) u_sync_vs (
    .clk(clk), .reset_n(reset_n), .din(gb_vsync), .edge_p(vs_rise)
  );

  // Data gets one flop beyond its synchronizer so it lines up with the
  // registered edge pulse, i.e. it is the value present when gb_clk fell.
  logic [SYNC_STAGES-1:0][1:0] d_sync_q;
  gb_pix_t                     d_dly_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_sync_q <= '0;
      d_dly_q  <= '0;
    end else begin
      d_sync_q <= {d_sync_q[SYNC_STAGES-2:0], gb_d};
      d_dly_q  <= d_sync_q[SYNC_STAGES-1];
    end
  end

  cap_state_t       state_q;
  logic [XW-1:0]    x_q;
  logic [YW-1:0]    y_q;
  logic [FB_AW-1:0] addr_q;
  logic [FB_AW-1:0] base_q;    // y*H_PIX, advanced by H_PIX per line
  logic             lerr_seen_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      addr_q      <= '0;
      base_q      <= '0;
      lerr_seen_q <= 1'b0;
      fb_wr_addr  <= '0;
      fb_wr_data  <= '0;
      fb_we       <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      line_err    <= 1'b0;
    end else begin
      fb_we      <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      line_err   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (vs_rise && capture_en) begin
            state_q     <= S_ACTIVE;
            x_q         <= '0;
            y_q         <= '0;
            addr_q      <= '0;
            base_q      <= '0;
            lerr_seen_q <= 1'b0;
          end
        end
        S_ACTIVE: begin
          // Priority vsync > hsync > pixel; a losing pixel edge is dropped.
          if (vs_rise) begin
            frame_err   <= 1'b1;
            x_q         <= '0;
            y_q         <= '0;
            addr_q      <= '0;
            base_q      <= '0;
            lerr_seen_q <= 1'b0;
            if (!capture_en) state_q <= S_IDLE;
          end else if (hs_rise) begin
            x_q         <= '0;
            lerr_seen_q <= 1'b0;
            if (y_q == YW'(V_LINES - 1)) begin
              frame_done <= 1'b1;
              state_q    <= S_IDLE;
            end else begin
              y_q    <= y_q + YW'(1);
              base_q <= base_q + FB_AW'(H_PIX);
              addr_q <= base_q + FB_AW'(H_PIX);
            end
          end else if (px_fall) begin
            if (x_q < XW'(H_PIX)) begin
              fb_we      <= 1'b1;
              fb_wr_addr <= addr_q;
              fb_wr_data <= d_dly_q;
              addr_q     <= addr_q + FB_AW'(1);
              x_q        <= x_q + XW'(1);
            end else if (!lerr_seen_q) begin
              line_err    <= 1'b1;
              lerr_seen_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef GB_CAPTURE_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [7:0]  err_cnt_q;

  // Counts follow the event pulses by one cycle; a simultaneous frame_err
  // and line_err counts once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (frame_done) frame_cnt_q <= frame_cnt_q + 16'd1;
      if ((frame_err || line_err) && (err_cnt_q != 8'hFF))
        err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign frame_count = frame_cnt_q;
  assign err_count   = err_cnt_q;
`else
  assign frame_count = 16'd0;
  assign err_count   = 8'd0;
`endif

endmodule

// File: tb/tb_gb_lcd_capture.sv
module tb_gb_lcd_capture;

  localparam int H  = 10;
  localparam int V  = 8;
  localparam int SS = 2;
  localparam int AW = 15;

`ifdef GB_CAPTURE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk;
  logic          reset_n;
  logic          gb_clk, gb_hsync, gb_vsync;
  logic [1:0]    gb_d;
  logic          capture_en;
  logic [AW-1:0] fb_wr_addr;
  logic [1:0]    fb_wr_data;
  logic          fb_we, frame_done, frame_err, line_err;
  logic [15:0]   frame_count;
  logic [7:0]    err_count;

  gb_lcd_capture #(.H_PIX(H), .V_LINES(V), .SYNC_STAGES(SS), .FB_AW(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .gb_clk(gb_clk), .gb_hsync(gb_hsync), .gb_vsync(gb_vsync), .gb_d(gb_d),
    .capture_en(capture_en),
    .fb_wr_addr(fb_wr_addr), .fb_wr_data(fb_wr_data), .fb_we(fb_we),
    .frame_done(frame_done), .frame_err(frame_err), .line_err(line_err),
    .frame_count(frame_count), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [1:0]    data;
  } wr_t;

  wr_t           exp_q[$];
  wr_t           exp_e;
  int            tests_run = 0;
  int            tests_failed = 0;
  int            n_we = 0, n_done = 0, n_ferr = 0, n_lerr = 0, lat_bad = 0;
  int            b_we, b_done, b_ferr, b_lerr;
  logic [AW-1:0] last_addr = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: each write strobe pops the oldest expected write.
  always @(negedge clk) begin
    if (fb_we) begin
      n_we++;
      last_addr = fb_wr_addr;
      check("sb_pending", 64'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        exp_e = exp_q.pop_front();
        check("wr_addr", 64'(fb_wr_addr), 64'(exp_e.addr));
        check("wr_data", 64'(fb_wr_data), 64'(exp_e.data));
      end
    end
    if (frame_done) n_done++;
    if (frame_err)  n_ferr++;
    if (line_err)   n_lerr++;
  end

  task automatic snap();
    b_we = n_we; b_done = n_done; b_ferr = n_ferr; b_lerr = n_lerr;
  endtask

  task automatic pixel(input logic [1:0] d, input bit exp_wr, input int addr);
    @(posedge clk); #1;
    gb_d = d; gb_clk = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    if (exp_wr) exp_q.push_back(wr_t'{addr: AW'(addr), data: d});
    gb_clk = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (exp_wr && fb_we && k != SS + 2) lat_bad++;
    end
  endtask

  task automatic hsync_pulse();
    @(posedge clk); #1; gb_hsync = 1'b1;
    repeat (3) @(posedge clk);
    #1; gb_hsync = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic vsync_pulse();
    @(posedge clk); #1; gb_vsync = 1'b1;
    repeat (3) @(posedge clk);
    #1; gb_vsync = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic send_line_from(input int y, input int x0, input int npix, input bit exp);
    for (int x = x0; x < npix; x++)
      pixel(2'((x + y) % 4), exp && (x < H), y * H + x);
    hsync_pulse();
  endtask

  task automatic send_lines(input int y0, input int y1, input bit exp);
    for (int y = y0; y <= y1; y++) send_line_from(y, 0, H, exp);
  endtask

  task automatic outputs_zero(input string p);
    check({p, "_fb_we"},       64'(fb_we), 0);
    check({p, "_fb_wr_addr"},  64'(fb_wr_addr), 0);
    check({p, "_fb_wr_data"},  64'(fb_wr_data), 0);
    check({p, "_frame_done"},  64'(frame_done), 0);
    check({p, "_frame_err"},   64'(frame_err), 0);
    check({p, "_line_err"},    64'(line_err), 0);
    check({p, "_frame_count"}, 64'(frame_count), 0);
    check({p, "_err_count"},   64'(err_count), 0);
  endtask

  initial begin
    reset_n = 1'b0; gb_clk = 1'b0; gb_hsync = 1'b0; gb_vsync = 1'b0;
    gb_d = 2'd0; capture_en = 1'b1;
    repeat (3) @(posedge clk);

    // Held in reset while the GB bus toggles: nothing may come out.
    vsync_pulse();
    for (int i = 0; i < 4; i++) pixel(2'(i), 1'b0, 0);
    hsync_pulse();
    check("rst_writes", 64'(n_we), 0);
    outputs_zero("rst");
    @(posedge clk); #1; reset_n = 1'b1;
    repeat (3) @(posedge clk);

    // Full frame, pattern (x+y)%4; frame_done only after the last hsync.
    snap();
    vsync_pulse();
    send_lines(0, V - 2, 1'b1);
    for (int x = 0; x < H; x++) pixel(2'((x + V - 1) % 4), 1'b1, (V - 1) * H + x);
    repeat (4) @(posedge clk);
    check("full_done_before_last_hs", 64'(n_done - b_done), 0);
    hsync_pulse();
    repeat (6) @(posedge clk);
    check("full_writes", 64'(n_we - b_we), 64'(H * V));
    check("full_done", 64'(n_done - b_done), 1);
    check("full_ferr", 64'(n_ferr - b_ferr), 0);
    check("full_lerr", 64'(n_lerr - b_lerr), 0);
    check("full_sb_drained", 64'(exp_q.size()), 0);
    check("latency", 64'(lat_bad), 0);

    // Overlong line 5 (H+2 pixels): H writes, one line_err, line 6 at 6*H.
    snap();
    vsync_pulse();
    send_lines(0, 4, 1'b1);
    send_line_from(5, 0, H + 2, 1'b1);
    check("long_writes", 64'(n_we - b_we), 64'(6 * H));
    check("long_lerr", 64'(n_lerr - b_lerr), 1);
    pixel(2'((0 + 6) % 4), 1'b1, 6 * H);
    check("long_next_line_addr", 64'(last_addr), 64'(6 * H));
    send_line_from(6, 1, H, 1'b1);
    send_lines(7, V - 1, 1'b1);
    repeat (6) @(posedge clk);
    check("long_done", 64'(n_done - b_done), 1);

    // Pixel edge coinciding with hsync is dropped; short frame then vsync.
    snap();
    vsync_pulse();
    for (int x = 0; x < 3; x++) pixel(2'(x % 4), 1'b1, x);
    @(posedge clk); #1; gb_d = 2'd3; gb_clk = 1'b1;
    repeat (3) @(posedge clk);
    #1; gb_clk = 1'b0; gb_hsync = 1'b1;
    repeat (3) @(posedge clk);
    #1; gb_hsync = 1'b0;
    repeat (3) @(posedge clk);
    check("prio_writes", 64'(n_we - b_we), 3);
    send_line_from(1, 0, H, 1'b1);
    check("prio_line1_end", 64'(last_addr), 64'(2 * H - 1));
    send_lines(2, 4, 1'b1);
    vsync_pulse();
    repeat (4) @(posedge clk);
    check("short_ferr", 64'(n_ferr - b_ferr), 1);
    check("short_no_done", 64'(n_done - b_done), 0);
    pixel(2'd0, 1'b1, 0);
    check("short_restart_addr", 64'(last_addr), 0);
    send_line_from(0, 1, H, 1'b1);
    send_lines(1, V - 1, 1'b1);
    repeat (6) @(posedge clk);
    check("short_then_done", 64'(n_done - b_done), 1);

    // capture_en low at vsync: nothing written.
    snap();
    capture_en = 1'b0;
    vsync_pulse();
    send_lines(0, V - 1, 1'b0);
    check("disarmed_writes", 64'(n_we - b_we), 0);
    check("disarmed_done", 64'(n_done - b_done), 0);

    // capture_en dropped mid-frame: the frame still completes.
    snap();
    capture_en = 1'b1;
    vsync_pulse();
    send_lines(0, 2, 1'b1);
    capture_en = 1'b0;
    send_lines(3, V - 1, 1'b1);
    repeat (6) @(posedge clk);
    check("drop_en_writes", 64'(n_we - b_we), 64'(H * V));
    check("drop_en_done", 64'(n_done - b_done), 1);

    // Reset mid-frame: outputs clear immediately, capture waits for vsync.
    capture_en = 1'b1;
    vsync_pulse();
    send_lines(0, 4, 1'b1);
    @(posedge clk); #1; reset_n = 1'b0;
    #1;
    outputs_zero("midrst");
    repeat (3) @(posedge clk);
    #1; reset_n = 1'b1;
    repeat (3) @(posedge clk);
    snap();
    send_line_from(0, 0, H, 1'b0);
    check("midrst_no_writes", 64'(n_we - b_we), 0);
    vsync_pulse();
    pixel(2'd0, 1'b1, 0);
    check("midrst_restart_addr", 64'(last_addr), 0);
    send_line_from(0, 1, H, 1'b1);
    send_lines(1, V - 1, 1'b1);
    repeat (6) @(posedge clk);
    check("midrst_done", 64'(n_done - b_done), 1);

    // Statistics: 3 good frames + 1 short frame, then saturation.
    @(posedge clk); #1; reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1; reset_n = 1'b1;
    repeat (3) @(posedge clk);
    snap();
    for (int f = 0; f < 3; f++) begin
      vsync_pulse();
      send_lines(0, V - 1, 1'b1);
    end
    vsync_pulse();
    send_lines(0, 3, 1'b1);
    vsync_pulse();
    repeat (4) @(posedge clk);
    check("stats_done_events", 64'(n_done - b_done), 3);
    check("stats_ferr_events", 64'(n_ferr - b_ferr), 1);
    check("stats_frame_count", 64'(frame_count), STATS ? 64'd3 : 64'd0);
    check("stats_err_count", 64'(err_count), STATS ? 64'd1 : 64'd0);
    snap();
    for (int i = 0; i < 300; i++) vsync_pulse();
    repeat (4) @(posedge clk);
    check("sat_ferr_events", 64'(n_ferr - b_ferr), 300);
    check("sat_err_count", 64'(err_count), STATS ? 64'd255 : 64'd0);
    check("sat_frame_count", 64'(frame_count), STATS ? 64'd3 : 64'd0);
    check("final_sb_drained", 64'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
